pe_db: RTL and testbench

Parametrised, double-buffered systolic processing element for the weight-stationary array. Each cycle it multiplies a streamed activation by a stationary weight, adds the partial sum from the PE above, and forwards the activation and the sum. A shadow weight register lets the next tile's weights be shifted in while the current tile computes; one swap strobe commits them with no pipeline bubble. Signed and unsigned operands are selectable per sample. It replaces the fixed 8-bit, separate-preload-clock PE in array generators.

---
 rtl/pe_db.sv | 71 +++++++
 tb/tb_pe_db.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pe_db.sv
// Double-buffered weight-stationary systolic PE: shadow weight chain, swap strobe,
// two-stage multiply / accumulate with per-sample signed or unsigned operands.
module pe_db #(
  parameter  int DW   = 8,
  parameter  int SIZE = 16,
  localparam int PW   = 2*DW + $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_load,
  input  logic [DW-1:0] w_in,
  output logic [DW-1:0] w_out,
  input  logic          w_swap,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_sgn,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sgn,
  input  logic [PW-1:0] psum_in,
  output logic          psum_valid,
  output logic [PW-1:0] psum_out
);

  localparam int FW = 2*DW + 2;

  logic [DW-1:0]        shadow;
  logic [DW-1:0]        active;
  logic [PW-1:0]        prod_r;
  logic                 vld1;
  logic signed [DW:0]   w_ext;
  logic signed [DW:0]   d_ext;
  logic signed [FW-1:0] prod_full;
  logic signed [PW-1:0] prod_pw;

  // One extra bit per operand lets a single signed multiplier serve both modes:
  // unsigned operands get a 0 MSB, signed ones replicate their sign bit.
  always_comb begin
    w_ext     = {in_sgn & active[DW-1], active};
    d_ext     = {in_sgn & in_data[DW-1], in_data};
    prod_full = FW'(w_ext) * FW'(d_ext);
    prod_pw   = PW'(prod_full);
  end

  assign w_out = shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      active     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sgn    <= 1'b0;
      prod_r     <= '0;
      vld1       <= 1'b0;
      psum_valid <= 1'b0;
      psum_out   <= '0;
    end else begin
      if (w_load) shadow <= w_in;
      if (w_swap) active <= shadow;
      out_valid  <= in_valid;
      out_data   <= in_data;
      out_sgn    <= in_sgn;
      prod_r     <= in_valid ? prod_pw : '0;
      vld1       <= in_valid;
      psum_out   <= prod_r + psum_in;
      psum_valid <= vld1;
    end
  end

endmodule

// File: tb/tb_pe_db.sv
// Randomized and directed bench for pe_db against an arithmetic reference model.
module tb_pe_db;
  localparam int DW   = 8;
  localparam int SIZE = 16;
  localparam int PW   = 2*DW + $clog2(SIZE);
  localparam longint MASK = (64'sd1 <<< PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_load, w_swap, in_valid, in_sgn;
  logic [DW-1:0] w_in, in_data, w_out, out_data;
  logic          out_valid, out_sgn, psum_valid;
  logic [PW-1:0] psum_in, psum_out;

  always #5 clk = ~clk;

  pe_db #(.DW(DW), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_out(w_out),
    .w_swap(w_swap), .in_valid(in_valid), .in_data(in_data), .in_sgn(in_sgn),
    .out_valid(out_valid), .out_data(out_data), .out_sgn(out_sgn),
    .psum_in(psum_in), .psum_valid(psum_valid), .psum_out(psum_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference state: weights as integers, the pending product as a signed number
  longint m_shadow, m_active, m_prod;
  bit     m_pv;
  bit     e_out_valid, e_out_sgn, e_psum_valid;
  longint e_out_data, e_psum_out;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint mul(input longint w, input longint d, input bit s);
    longint a, b;
    a = w;
    b = d;
    if (s) begin
      if (a >= (64'sd1 <<< (DW-1))) a = a - (64'sd1 <<< DW);
      if (b >= (64'sd1 <<< (DW-1))) b = b - (64'sd1 <<< DW);
    end
    return a * b;
  endfunction

  task automatic clear_model();
    m_shadow = 0; m_active = 0; m_prod = 0; m_pv = 0;
    e_out_valid = 0; e_out_sgn = 0; e_psum_valid = 0;
    e_out_data = 0; e_psum_out = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"},  longint'(out_valid),  longint'(e_out_valid));
    chk({tag, ".out_data"},   longint'(out_data),   e_out_data);
    chk({tag, ".out_sgn"},    longint'(out_sgn),    longint'(e_out_sgn));
    chk({tag, ".w_out"},      longint'(w_out),      m_shadow);
    chk({tag, ".psum_valid"}, longint'(psum_valid), longint'(e_psum_valid));
    chk({tag, ".psum_out"},   longint'(psum_out),   e_psum_out);
  endtask

  // Drive one cycle at the negedge, advance the model at the posedge, check at the next negedge.
  task automatic step(input string tag, input bit ld, input int wi, input bit sw,
                      input bit v, input int d, input bit s, input longint ps);
    w_load = ld; w_in = DW'(wi); w_swap = sw;
    in_valid = v; in_data = DW'(d); in_sgn = s; psum_in = PW'(ps);
    @(posedge clk);
    e_psum_out   = (m_prod + (ps & MASK)) & MASK;
    e_psum_valid = m_pv;
    m_prod       = v ? mul(longint'(wi & 'hFF) & ((64'sd1 <<< DW) - 1) & m_active | 0, 0, 0) : 0;
    m_prod       = v ? mul(m_active, longint'(d) & ((64'sd1 <<< DW) - 1), s) : 0;
    m_pv         = v;
    e_out_valid  = v;
    e_out_data   = longint'(d) & ((64'sd1 <<< DW) - 1);
    e_out_sgn    = s;
    if (sw) m_active = m_shadow;
    if (ld) m_shadow = longint'(wi) & ((64'sd1 <<< DW) - 1);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic rand_step(input string tag, input bit force_valid);
    step(tag, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
         1'($urandom_range(0, 3) == 0),
         force_valid ? 1'b1 : 1'($urandom_range(0, 3) != 0),
         int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
         longint'($urandom) & MASK);
  endtask

  initial begin
    rst = 1'b1;
    w_load = 0; w_in = '0; w_swap = 0; in_valid = 0; in_data = '0; in_sgn = 0; psum_in = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // unsigned max
    step("umax", 1, 255, 0, 0, 0, 0, 0);
    step("umax", 0, 0, 1, 0, 0, 0, 0);
    step("umax", 0, 0, 0, 1, 255, 0, 0);
    chk("umax_fwd", longint'(out_data), 255);
    step("umax", 0, 0, 0, 0, 0, 0, 0);
    chk("umax_psum", longint'(psum_out), 65025);
    chk("umax_pv", longint'(psum_valid), 1);

    // signed -128 * -128, then 5 * -1 + 3
    step("sgn", 1, 'h80, 0, 0, 0, 0, 0);
    step("sgn", 0, 0, 1, 0, 0, 0, 0);
    step("sgn", 0, 0, 0, 1, 'h80, 1, 0);
    step("sgn", 1, 5, 0, 0, 0, 0, 0);
    chk("sgn_m128", longint'(psum_out), 16384);
    step("sgn", 0, 0, 1, 0, 0, 0, 0);
    step("sgn", 0, 0, 0, 1, 'hFF, 1, 0);
    step("sgn", 0, 0, 0, 0, 0, 0, 3);
    chk("sgn_neg", longint'(psum_out), 'hFFFFE);

    // swap and load on the same edge as a sample
    step("race", 1, 2, 0, 0, 0, 0, 0);
    step("race", 0, 0, 1, 0, 0, 0, 0);
    step("race", 1, 7, 0, 0, 0, 0, 0);
    step("race", 1, 9, 1, 1, 3, 0, 0);
    step("race", 0, 0, 0, 1, 3, 0, 0);
    chk("race_p1", longint'(psum_out), 6);
    step("race", 0, 0, 0, 0, 0, 0, 0);
    chk("race_p2", longint'(psum_out), 21);
    chk("race_wout", longint'(w_out), 9);

    // modulo wrap
    step("wrap", 1, 1, 0, 0, 0, 0, 0);
    step("wrap", 0, 0, 1, 0, 0, 0, 0);
    step("wrap", 0, 0, 0, 1, 1, 0, 0);
    step("wrap", 0, 0, 0, 0, 0, 0, 'hFFFFF);
    chk("wrap_psum", longint'(psum_out), 0);

    // back-to-back stream then a bubble
    for (int i = 0; i < 8; i++) rand_step("stream", 1'b1);
    step("bubble", 0, 0, 0, 0, 0, 0, longint'($urandom) & MASK);
    step("bubble", 0, 0, 0, 0, 0, 0, 'h123);
    chk("bubble_pv", longint'(psum_valid), 0);
    chk("bubble_psum", longint'(psum_out), 'h123);

    // random traffic
    for (int i = 0; i < 500; i++) rand_step("rand", 1'b0);

    // asynchronous reset within a cycle
    step("mid", 1, 'h33, 1, 1, 'h44, 0, 'h55);
    step("mid", 1, 'h66, 1, 1, 'h77, 1, 'h88);
    w_load = 0; w_in = '0; w_swap = 0; in_valid = 0; in_data = '0; in_sgn = 0; psum_in = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_w_out", longint'(w_out), 0);
    chk("rst_psum_valid", longint'(psum_valid), 0);
    chk("rst_psum_out", longint'(psum_out), 0);
    #1 rst = 1'b0;
    clear_model();
    step("postrst", 0, 0, 0, 0, 0, 0, 0);
    step("postrst", 0, 0, 0, 0, 0, 0, 0);
    chk("postrst_psum", longint'(psum_out), 0);
    step("reload", 1, 3, 0, 0, 0, 0, 0);
    step("reload", 0, 0, 1, 0, 0, 0, 0);
    step("reload", 0, 0, 0, 1, 4, 0, 0);
    step("reload", 0, 0, 0, 0, 0, 0, 0);
    chk("reload_psum", longint'(psum_out), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
